weight_loader: RTL and testbench

//  Write-side sequencer for the weight memory: accepts a valid/ready stream of

---
 rtl/weight_pkg.sv | 19 +
 rtl/weight_loader_if.sv | 30 +++
 rtl/idx_counter4.sv | 62 ++++++
 rtl/weight_loader.sv | 97 +++++++++
 tb/tb_weight_loader.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_pkg.sv
// Types shared by the weight memory write-side and read-side sequencers.
package weight_pkg;

   localparam int IDX_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } wl_state_t;

   typedef struct packed {
      logic [IDX_W_DEF-1:0] idx_in;
      logic [IDX_W_DEF-1:0] idx_out;
      logic [IDX_W_DEF-1:0] k_y;
      logic [IDX_W_DEF-1:0] k_x;
   } idx_tuple_t;

endpackage

// File: rtl/weight_loader_if.sv
// Weight stream in / weight memory write port out, plus start/busy/done control.
interface weight_loader_if import weight_pkg::*; #(
   parameter int DATA_SIZE = 64,
   parameter int IDX_W     = IDX_W_DEF
);
   logic                 start;
   logic                 s_valid;
   logic                 s_ready;
   logic [DATA_SIZE-1:0] s_data;
   logic                 write;
   logic [IDX_W-1:0]     index_in;
   logic [IDX_W-1:0]     index_out;
   logic [IDX_W-1:0]     index_k_y;
   logic [IDX_W-1:0]     index_k_x;
   logic [DATA_SIZE-1:0] in_data;
   logic                 busy;
   logic                 done;

   modport master (
      output start, s_valid, s_data,
      input  s_ready, write, index_in, index_out, index_k_y, index_k_x,
             in_data, busy, done
   );

   modport slave (
      input  start, s_valid, s_data,
      output s_ready, write, index_in, index_out, index_k_y, index_k_x,
             in_data, busy, done
   );
endinterface

// File: rtl/idx_counter4.sv
// Four-level wrapping index counter (k_x fastest, then k_y, out, in); clear beats inc.
// o_all_max flags the final tuple so the owner can stop before the counter wraps.
module idx_counter4 import weight_pkg::*; #(
   parameter int IDX_W = IDX_W_DEF,
   parameter int MAX_X = 0,
   parameter int MAX_Y = 0,
   parameter int MAX_O = 0,
   parameter int MAX_I = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [IDX_W-1:0] o_k_x,
   output logic [IDX_W-1:0] o_k_y,
   output logic [IDX_W-1:0] o_out,
   output logic [IDX_W-1:0] o_in,
   output logic             o_all_max
);
   localparam logic [IDX_W-1:0] L_MX  = IDX_W'(MAX_X);
   localparam logic [IDX_W-1:0] L_MY  = IDX_W'(MAX_Y);
   localparam logic [IDX_W-1:0] L_MO  = IDX_W'(MAX_O);
   localparam logic [IDX_W-1:0] L_MI  = IDX_W'(MAX_I);
   localparam logic [IDX_W-1:0] L_ONE = IDX_W'(1);

   logic [IDX_W-1:0] r_x, r_y, r_o, r_i;
   logic             w_x_max, w_y_max, w_o_max, w_i_max;

   assign w_x_max = (r_x == L_MX);
   assign w_y_max = (r_y == L_MY);
   assign w_o_max = (r_o == L_MO);
   assign w_i_max = (r_i == L_MI);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
         r_o <= '0;
         r_i <= '0;
      end else if (i_clear) begin
         r_x <= '0;
         r_y <= '0;
         r_o <= '0;
         r_i <= '0;
      end else if (i_inc) begin
         // Each level advances only when every faster level wraps this beat.
         r_x <= w_x_max ? '0 : r_x + L_ONE;
         if (w_x_max)
            r_y <= w_y_max ? '0 : r_y + L_ONE;
         if (w_x_max && w_y_max)
            r_o <= w_o_max ? '0 : r_o + L_ONE;
         if (w_x_max && w_y_max && w_o_max)
            r_i <= w_i_max ? '0 : r_i + L_ONE;
      end
   end

   assign o_k_x     = r_x;
   assign o_k_y     = r_y;
   assign o_out     = r_o;
   assign o_in      = r_i;
   assign o_all_max = w_x_max & w_y_max & w_o_max & w_i_max;
endmodule

// File: rtl/weight_loader.sv
// Weight memory write sequencer: one registered write per accepted beat, 1-cycle latency.
// s_ready is high only in LOAD and drops on the edge that accepts the last beat.
module weight_loader import weight_pkg::*; #(
   parameter int NUM_INPUTS  = 1,
   parameter int NUM_OUTPUTS = 1,
   parameter int DIM         = 1,
   parameter int DATA_SIZE   = 64,
   parameter int IDX_W       = IDX_W_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   weight_loader_if.slave  bus
);
   wl_state_t            r_state, w_next;
   logic                 w_accept, w_clear, w_all_max;
   logic [IDX_W-1:0]     w_cx, w_cy, w_co, w_ci;
   logic                 r_write;
   logic [IDX_W-1:0]     r_idx_in, r_idx_out, r_idx_ky, r_idx_kx;
   logic [DATA_SIZE-1:0] r_in_data;

   assign w_accept = (r_state == LOAD) & bus.s_valid;
   assign w_clear  = (r_state == IDLE) & bus.start;

   idx_counter4 #(
      .IDX_W (IDX_W),
      .MAX_X (DIM - 1),
      .MAX_Y (DIM - 1),
      .MAX_O (NUM_OUTPUTS - 1),
      .MAX_I (NUM_INPUTS - 1)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (w_clear),
      .i_inc     (w_accept),
      .o_k_x     (w_cx),
      .o_k_y     (w_cy),
      .o_out     (w_co),
      .o_in      (w_ci),
      .o_all_max (w_all_max)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      bus.s_ready = 1'b0;
      bus.busy    = 1'b0;
      bus.done    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) w_next = LOAD;
         end
         LOAD: begin
            bus.s_ready = 1'b1;
            bus.busy    = 1'b1;
            if (w_accept && w_all_max) w_next = FLUSH;
         end
         FLUSH: begin
            // The last write is on the port during this cycle.
            bus.busy = 1'b1;
            bus.done = 1'b1;
            w_next   = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write   <= 1'b0;
         r_idx_in  <= '0;
         r_idx_out <= '0;
         r_idx_ky  <= '0;
         r_idx_kx  <= '0;
         r_in_data <= '0;
      end else begin
         r_write <= w_accept;
         if (w_accept) begin
            r_idx_in  <= w_ci;
            r_idx_out <= w_co;
            r_idx_ky  <= w_cy;
            r_idx_kx  <= w_cx;
            r_in_data <= bus.s_data;
         end
      end
   end

   assign bus.write     = r_write;
   assign bus.index_in  = r_idx_in;
   assign bus.index_out = r_idx_out;
   assign bus.index_k_y = r_idx_ky;
   assign bus.index_k_x = r_idx_kx;
   assign bus.in_data   = r_in_data;
endmodule

// File: tb/tb_weight_loader.sv
// Bench for weight_loader: 2x2x3x3 instance against a beat-count reference model, plus a 1x1x1x1 instance.
module tb_weight_loader;
   import weight_pkg::*;

   localparam int NI  = 2;
   localparam int NO  = 2;
   localparam int D   = 3;
   localparam int TOT = NI * NO * D * D;

   typedef struct {
      int          beat;
      int          ei, eo, ey, ex;
      logic [63:0] ed;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   weight_loader_if #(.DATA_SIZE(64), .IDX_W(16)) ifa ();
   weight_loader_if #(.DATA_SIZE(64), .IDX_W(16)) ifb ();

   weight_loader #(.NUM_INPUTS(NI), .NUM_OUTPUTS(NO), .DIM(D), .DATA_SIZE(64), .IDX_W(16))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   weight_loader #(.NUM_INPUTS(1), .NUM_OUTPUTS(1), .DIM(1), .DATA_SIZE(64), .IDX_W(16))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

   int          n_vec = 0;
   int          n_bad = 0;
   bit          m_busy, m_load, m_done;
   int          m_beats;
   idx_tuple_t  m_idx;
   logic [63:0] m_data;
   idx_tuple_t  wlog[$];
   logic [63:0] dlog[$];
   int          n_done;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Expected tuple for beat n of a row-major [in][out][k_y][k_x] walk.
   function automatic idx_tuple_t beat_idx(input int n);
      idx_tuple_t t;
      t.idx_in  = 16'(n / (NO * D * D));
      t.idx_out = 16'((n / (D * D)) % NO);
      t.k_y     = 16'((n / D) % D);
      t.k_x     = 16'(n % D);
      return t;
   endfunction

   task automatic model_clear();
      m_busy  = 1'b0;
      m_load  = 1'b0;
      m_done  = 1'b0;
      m_beats = 0;
      m_idx   = '0;
      m_data  = '0;
   endtask

   task automatic cyc_a(input logic v, input logic [63:0] d, input logic st);
      logic       acc;
      idx_tuple_t t;
      ifa.start   = st;
      ifa.s_valid = v;
      ifa.s_data  = d;
      chk("a_s_ready", 64'(ifa.s_ready), 64'(m_load));
      acc = v && m_load;
      @(posedge clk);
      #1;
      if (m_done) begin
         m_busy = 1'b0;
         m_done = 1'b0;
      end else if (!m_busy && st) begin
         m_busy  = 1'b1;
         m_load  = 1'b1;
         m_beats = 0;
      end else if (acc) begin
         m_idx  = beat_idx(m_beats);
         m_data = d;
         m_beats++;
         if (m_beats == TOT) begin
            m_load = 1'b0;
            m_done = 1'b1;
         end
      end
      chk("a_write",   64'(ifa.write),     64'(acc));
      chk("a_busy",    64'(ifa.busy),      64'(m_busy));
      chk("a_done",    64'(ifa.done),      64'(m_done));
      chk("a_idx_in",  64'(ifa.index_in),  64'(m_idx.idx_in));
      chk("a_idx_out", 64'(ifa.index_out), 64'(m_idx.idx_out));
      chk("a_idx_ky",  64'(ifa.index_k_y), 64'(m_idx.k_y));
      chk("a_idx_kx",  64'(ifa.index_k_x), 64'(m_idx.k_x));
      chk("a_data",    ifa.in_data,        m_data);
      if (ifa.write) begin
         t.idx_in  = ifa.index_in;
         t.idx_out = ifa.index_out;
         t.k_y     = ifa.index_k_y;
         t.k_x     = ifa.index_k_x;
         wlog.push_back(t);
         dlog.push_back(ifa.in_data);
      end
      if (ifa.done) n_done++;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      ifa.start   = 1'b0;
      ifa.s_valid = 1'b1;
      ifb.start   = 1'b0;
      ifb.s_valid = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("rst_a_s_ready", 64'(ifa.s_ready),   64'd0);
         chk("rst_a_write",   64'(ifa.write),     64'd0);
         chk("rst_a_busy",    64'(ifa.busy),      64'd0);
         chk("rst_a_done",    64'(ifa.done),      64'd0);
         chk("rst_a_idx_in",  64'(ifa.index_in),  64'd0);
         chk("rst_a_idx_out", 64'(ifa.index_out), 64'd0);
         chk("rst_a_idx_ky",  64'(ifa.index_k_y), 64'd0);
         chk("rst_a_idx_kx",  64'(ifa.index_k_x), 64'd0);
         chk("rst_a_data",    ifa.in_data,        64'd0);
         chk("rst_b_s_ready", 64'(ifb.s_ready),   64'd0);
         chk("rst_b_write",   64'(ifb.write),     64'd0);
      end
      model_clear();
      ifb.s_valid = 1'b0;
      rst_n       = 1'b1;
   endtask

   task automatic log_clear();
      wlog.delete();
      dlog.delete();
      n_done = 0;
   endtask

   initial begin
      vec_t        tbl[5];
      idx_tuple_t  t;
      logic        v, st;
      logic [63:0] d;

      tbl[0] = '{0,  0, 0, 0, 0, 64'd0};
      tbl[1] = '{3,  0, 0, 1, 0, 64'd3};
      tbl[2] = '{9,  0, 1, 0, 0, 64'd9};
      tbl[3] = '{18, 1, 0, 0, 0, 64'd18};
      tbl[4] = '{35, 1, 1, 2, 2, 64'd35};

      ifa.start = 1'b0; ifa.s_valid = 1'b0; ifa.s_data = '0;
      ifb.start = 1'b0; ifb.s_valid = 1'b0; ifb.s_data = '0;
      model_clear();
      log_clear();
      do_reset();

      // Continuous stream, data = beat number.
      log_clear();
      cyc_a(1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 40; i++) cyc_a(1'b1, 64'(m_beats), 1'b0);
      chk("full_writes", 64'(wlog.size()), 64'(TOT));
      chk("full_done",   64'(n_done),      64'd1);
      for (int i = 0; i < 5; i++) begin
         if (tbl[i].beat < wlog.size()) begin
            t = wlog[tbl[i].beat];
            chk("tbl_in",   64'(t.idx_in),  64'(tbl[i].ei));
            chk("tbl_out",  64'(t.idx_out), 64'(tbl[i].eo));
            chk("tbl_ky",   64'(t.k_y),     64'(tbl[i].ey));
            chk("tbl_kx",   64'(t.k_x),     64'(tbl[i].ex));
            chk("tbl_data", dlog[tbl[i].beat], tbl[i].ed);
         end else begin
            chk("tbl_missing", 64'(wlog.size()), 64'(tbl[i].beat + 1));
         end
      end

      // Valid toggling every cycle.
      log_clear();
      cyc_a(1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 90; i++) cyc_a((i % 2) == 0, 64'(m_beats) + 64'h100, 1'b0);
      chk("toggle_writes", 64'(wlog.size()), 64'(TOT));
      chk("toggle_done",   64'(n_done),      64'd1);

      // Second start while busy must be ignored.
      log_clear();
      cyc_a(1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 45; i++) cyc_a(1'b1, 64'(m_beats), m_beats == 10);
      chk("restart_writes", 64'(wlog.size()), 64'(TOT));
      chk("restart_done",   64'(n_done),      64'd1);

      // Reset after beat 20 abandons the load; new load restarts at zero.
      log_clear();
      cyc_a(1'b0, 64'd0, 1'b1);
      for (int i = 0; i < 25 && m_beats < 20; i++) cyc_a(1'b1, 64'(m_beats), 1'b0);
      chk("abort_writes", 64'(wlog.size()), 64'd20);
      do_reset();
      log_clear();
      for (int i = 0; i < 4; i++) cyc_a(1'b1, 64'h55, 1'b0);
      chk("post_rst_no_write", 64'(wlog.size()), 64'd0);
      cyc_a(1'b0, 64'd0, 1'b1);
      cyc_a(1'b1, 64'hABC, 1'b0);
      if (wlog.size() == 1) begin
         t = wlog[0];
         chk("reload_first_idx",  64'(t), 64'd0);
         chk("reload_first_data", dlog[0], 64'hABC);
      end else begin
         chk("reload_first_count", 64'(wlog.size()), 64'd1);
      end
      for (int i = 0; i < 45; i++) cyc_a(1'b1, 64'(m_beats), 1'b0);

      // Randomized valid, data and stray start pulses.
      for (int i = 0; i < 400; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 15) == 0);
         d  = {$urandom, $urandom};
         cyc_a(v, d, st);
      end

      // Degenerate 1x1x1x1 instance.
      ifa.s_valid = 1'b0;
      ifb.start   = 1'b1;
      ifb.s_valid = 1'b0;
      @(posedge clk); #1;
      chk("b_busy_after_start",  64'(ifb.busy),    64'd1);
      chk("b_ready_after_start", 64'(ifb.s_ready), 64'd1);
      chk("b_no_write_yet",      64'(ifb.write),   64'd0);
      ifb.start   = 1'b0;
      ifb.s_valid = 1'b1;
      ifb.s_data  = 64'h3FF0000000000000;
      @(posedge clk); #1;
      chk("b_write",   64'(ifb.write),     64'd1);
      chk("b_done",    64'(ifb.done),      64'd1);
      chk("b_busy",    64'(ifb.busy),      64'd1);
      chk("b_ready",   64'(ifb.s_ready),   64'd0);
      chk("b_idx",     64'({ifb.index_in, ifb.index_out, ifb.index_k_y, ifb.index_k_x}), 64'd0);
      chk("b_data",    ifb.in_data,        64'h3FF0000000000000);
      @(posedge clk); #1;
      chk("b_write_end", 64'(ifb.write),   64'd0);
      chk("b_done_end",  64'(ifb.done),    64'd0);
      chk("b_busy_end",  64'(ifb.busy),    64'd0);
      chk("b_ready_end", 64'(ifb.s_ready), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
